// File: rtl/ucq_in_min_queue_pkg.sv
// Literal type and helpers shared by the UCQ_IN queue, its slot cells and the UC arbiter.
package ucq_in_min_queue_pkg;

    localparam int LIT_IDX_MAX = 255;
    localparam int LIT_IDX_W   = $clog2(LIT_IDX_MAX) + 1;

    typedef logic [LIT_IDX_W-1:0] lit_idx_t;

    typedef struct packed {
        logic     pol;
        lit_idx_t idx;
    } lit_t;

    localparam lit_t NULL_LIT = '0;

    function automatic lit_idx_t lit_idx(input lit_t l);
        return l.idx;
    endfunction

    function automatic lit_t lit_neg(input lit_t l);
        lit_t r;
        r     = l;
        r.pol = ~l.pol;
        return r;
    endfunction

endpackage

// File: rtl/ucq_in_min_queue_slot.sv
// One storage cell of the sorted literal queue: holds a literal plus its valid bit and
// loads from the new literal or from either neighbour as directed by the top.
module ucq_slot
    import ucq_in_min_queue_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic insert_here,
    input  logic shift_up,
    input  logic shift_down,
    input  lit_t new_lit,
    input  lit_t lower_lit,
    input  logic lower_valid,
    input  lit_t upper_lit,
    input  logic upper_valid,
    output lit_t lit,
    output logic valid
);

    lit_t lit_q;
    lit_t lit_d;
    logic valid_q;
    logic valid_d;

    // Invalid slots always hold NULL_LIT so the head can feed eng2uca_min straight from flops.
    always_comb begin
        lit_d   = lit_q;
        valid_d = valid_q;
        if (clear) begin
            lit_d   = NULL_LIT;
            valid_d = 1'b0;
        end else if (insert_here) begin
            lit_d   = new_lit;
            valid_d = 1'b1;
        end else if (shift_up) begin
            lit_d   = lower_lit;
            valid_d = lower_valid;
        end else if (shift_down) begin
            lit_d   = upper_lit;
            valid_d = upper_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lit_q   <= NULL_LIT;
            valid_q <= 1'b0;
        end else begin
            lit_q   <= lit_d;
            valid_q <= valid_d;
        end
    end

    assign lit   = lit_q;
    assign valid = valid_q;

endmodule

// File: rtl/ucq_in_min_queue.sv
// Per-engine UCQ_IN: sorted insertion queue of implied unit literals presenting the
// lowest-variable-index literal to the UC arbiter; drops duplicates, flags complements.
module ucq_in_min_queue
    import ucq_in_min_queue_pkg::*;
#(
    parameter  int DEPTH        = 8,
    parameter  int AFULL_THRESH = 6,
    localparam int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bcp2q_valid,
    input  lit_t             bcp2q_lit,
    output logic             bcp2q_ready,
    input  logic             flush,
    input  logic             uca2eng_pop,
    output lit_t             eng2uca_min,
    output logic             eng2uca_valid,
    output logic             eng2uca_empty,
    output logic             eng2uca_full,
    output logic             eng2uca_afull,
    output logic [CNT_W-1:0] count,
    output logic             conflict,
    output logic             overflow
);

    lit_t             slot_lit [DEPTH];
    logic [DEPTH-1:0] slot_valid;

    lit_t             ext_lit [DEPTH+2];
    logic [DEPTH+1:0] ext_valid;

    logic [DEPTH-1:0] insert_here;
    logic [DEPTH-1:0] shift_up;
    logic [DEPTH-1:0] shift_down;

    logic             pop_acc;
    logic             push_req;
    logic             push_acc;
    logic             dup_hit;
    logic             comp_hit;
    logic             full_w;
    logic [CNT_W-1:0] ins_pos;
    logic [CNT_W-1:0] pop_ins_pos;
    logic             ins_found;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             conflict_q;
    logic             conflict_d;
    logic             overflow_q;
    logic             overflow_d;

    // Pad the slot array with an empty cell at each end so every slot sees two neighbours.
    always_comb begin
        ext_lit[0]         = NULL_LIT;
        ext_valid[0]       = 1'b0;
        ext_lit[DEPTH+1]   = NULL_LIT;
        ext_valid[DEPTH+1] = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            ext_lit[k+1]   = slot_lit[k];
            ext_valid[k+1] = slot_valid[k];
        end
    end

    assign full_w   = (count_q == CNT_W'(DEPTH));
    assign pop_acc  = uca2eng_pop & slot_valid[0] & ~flush;
    assign push_req = bcp2q_valid & ~flush & (lit_idx(bcp2q_lit) != '0);

    // Matching includes a head being popped this cycle, so a same-cycle re-push is still a duplicate.
    always_comb begin
        dup_hit  = 1'b0;
        comp_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i] && (slot_lit[i] == bcp2q_lit)) begin
                dup_hit = 1'b1;
            end
            if (slot_valid[i] && (slot_lit[i] == lit_neg(bcp2q_lit))) begin
                comp_hit = 1'b1;
            end
        end
    end

    always_comb begin
        ins_pos   = count_q;
        ins_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!ins_found && slot_valid[i] &&
                (lit_idx(slot_lit[i]) > lit_idx(bcp2q_lit))) begin
                ins_pos   = CNT_W'(i);
                ins_found = 1'b1;
            end
        end
    end

    // With a concurrent pop the remaining entries slide down by one, so the slot index drops too.
    assign pop_ins_pos = (ins_pos == '0) ? '0 : ins_pos - CNT_W'(1);
    assign push_acc    = push_req & ~dup_hit & ~comp_hit & (~full_w | pop_acc);

    always_comb begin
        insert_here = '0;
        shift_up    = '0;
        shift_down  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (push_acc && pop_acc) begin
                if (CNT_W'(i) < pop_ins_pos) begin
                    shift_down[i] = 1'b1;
                end else if (CNT_W'(i) == pop_ins_pos) begin
                    insert_here[i] = 1'b1;
                end
            end else if (push_acc) begin
                if (CNT_W'(i) == ins_pos) begin
                    insert_here[i] = 1'b1;
                end else if (CNT_W'(i) > ins_pos) begin
                    shift_up[i] = 1'b1;
                end
            end else if (pop_acc) begin
                shift_down[i] = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        ucq_slot u_slot (
            .clk         (clk),
            .rst         (rst),
            .clear       (flush),
            .insert_here (insert_here[i]),
            .shift_up    (shift_up[i]),
            .shift_down  (shift_down[i]),
            .new_lit     (bcp2q_lit),
            .lower_lit   (ext_lit[i]),
            .lower_valid (ext_valid[i]),
            .upper_lit   (ext_lit[i+2]),
            .upper_valid (ext_valid[i+2]),
            .lit         (slot_lit[i]),
            .valid       (slot_valid[i])
        );
    end

    always_comb begin
        count_d    = count_q + CNT_W'(push_acc) - CNT_W'(pop_acc);
        conflict_d = conflict_q | (push_req & comp_hit);
        overflow_d = overflow_q | (push_req & ~dup_hit & ~comp_hit & full_w & ~pop_acc);
        if (flush) begin
            count_d    = '0;
            conflict_d = 1'b0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            conflict_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            conflict_q <= conflict_d;
            overflow_q <= overflow_d;
        end
    end

    assign eng2uca_min   = slot_lit[0];
    assign eng2uca_valid = slot_valid[0];
    assign eng2uca_empty = ~slot_valid[0];
    assign eng2uca_full  = full_w;
    assign eng2uca_afull = (count_q >= CNT_W'(AFULL_THRESH));
    assign bcp2q_ready   = ~full_w | uca2eng_pop;
    assign count         = count_q;
    assign conflict      = conflict_q;
    assign overflow      = overflow_q;

endmodule
